mmu_xlate_pipe: RTL and testbench



---
 rtl/mmu_xlate_pipe.sv | 233 +++++++++++++++++++++++
 tb/tb_mmu_xlate_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_xlate_pipe.sv
// Handshaked VA->PA translation (DA / DMW / TLB-map) with a small fully-associative
// micro-TLB in front of the main TLB search port. One request in flight at a time.
module mmu_xlate_pipe #(
  parameter int TLBNUM   = 16,
  parameter int UTLB_NUM = 4,
  parameter int NUM_DMW  = 2,
  parameter int PALEN    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_va,
  input  logic [2:0]                req_type,
  input  logic [31:0]               csr_crmd,
  input  logic [32*NUM_DMW-1:0]     csr_dmw,
  input  logic [9:0]                csr_asid,
  input  logic                      flush,
  output logic                      tlb_s_valid,
  output logic [18:0]               tlb_s_vppn,
  output logic                      tlb_s_va_bit12,
  output logic [9:0]                tlb_s_asid,
  input  logic                      tlb_s_found,
  input  logic [$clog2(TLBNUM)-1:0] tlb_s_index,
  input  logic [19:0]               tlb_s_ppn,
  input  logic [5:0]                tlb_s_ps,
  input  logic [1:0]                tlb_s_plv,
  input  logic [1:0]                tlb_s_mat,
  input  logic                      tlb_s_d,
  input  logic                      tlb_s_v,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [PALEN-1:0]          resp_pa,
  output logic [1:0]                resp_mat,
  output logic [5:0]                resp_except,
  output logic                      resp_has_except
);
  localparam int IDXW = $clog2(UTLB_NUM);

  typedef enum logic [1:0] {IDLE, CHECK, WALK, RESP} state_t;
  state_t state, state_n;

  logic [31:0]           va_q, crmd_q;
  logic [2:0]            type_q;
  logic [32*NUM_DMW-1:0] dmw_q;
  logic [9:0]            asid_q;
  logic [PALEN-1:0]      pa_q;
  logic [1:0]            mat_q;
  logic [5:0]            exc_q;

  logic [UTLB_NUM-1:0] ut_valid, ut_ps4m, ut_d, ut_v;
  logic [19:0]         ut_tag [UTLB_NUM];
  logic [9:0]          ut_asid [UTLB_NUM];
  logic [19:0]         ut_ppn [UTLB_NUM];
  logic [1:0]          ut_plv [UTLB_NUM];
  logic [1:0]          ut_mat [UTLB_NUM];
  logic [IDXW-1:0]     rr_ptr, ut_sel, victim;
  logic                ut_hit, has_free;

  logic        dmw_hit;
  logic [31:0] dmw_pa, win;
  logic [1:0]  dmw_mat;

  logic        m_found, m_v, m_d, m_ps4m, ppi, pme, pi;
  logic [1:0]  m_plv, m_mat;
  logic [19:0] m_ppn;
  logic [31:0] map_pa;
  logic [5:0]  map_exc;

  logic        ld_resp;
  logic [31:0] nx_pa;
  logic [1:0]  nx_mat;
  logic [5:0]  nx_exc;

  assign req_ready       = (state == IDLE);
  assign resp_valid      = (state == RESP);
  assign resp_pa         = pa_q;
  assign resp_mat        = mat_q;
  assign resp_except     = exc_q;
  assign resp_has_except = |exc_q;
  assign tlb_s_vppn      = va_q[31:13];
  assign tlb_s_va_bit12  = va_q[12];
  assign tlb_s_asid      = asid_q;

  always_comb begin
    dmw_hit = 1'b0;
    dmw_pa  = '0;
    dmw_mat = '0;
    win     = '0;
    for (int unsigned i = 0; i < NUM_DMW; i++) begin
      win = dmw_q[32*i +: 32];
      if (!dmw_hit && va_q[31:29] == win[31:29] &&
          ((win[0] && crmd_q[1:0] == 2'd0) || (win[3] && crmd_q[1:0] == 2'd3))) begin
        dmw_hit = 1'b1;
        dmw_pa  = {win[27:25], va_q[28:0]};
        dmw_mat = win[5:4];
      end
    end
  end

  always_comb begin
    ut_hit   = 1'b0;
    ut_sel   = '0;
    has_free = 1'b0;
    victim   = rr_ptr;
    for (int unsigned i = 0; i < UTLB_NUM; i++) begin
      if (ut_valid[i] && ut_asid[i] == asid_q &&
          (ut_ps4m[i] ? ut_tag[i][19:10] == va_q[31:22] : ut_tag[i] == va_q[31:12])) begin
        ut_hit = 1'b1;
        ut_sel = IDXW'(i);
      end
      if (!has_free && !ut_valid[i]) begin
        has_free = 1'b1;
        victim   = IDXW'(i);
      end
    end
  end

  // Walk and uTLB-hit results share one datapath; only the source of the entry differs.
  always_comb begin
    if (state == WALK) begin
      m_found = tlb_s_found;
      m_v     = tlb_s_v;
      m_d     = tlb_s_d;
      m_plv   = tlb_s_plv;
      m_mat   = tlb_s_mat;
      m_ppn   = tlb_s_ppn;
      m_ps4m  = (tlb_s_ps == 6'd21);
    end else begin
      m_found = 1'b1;
      m_v     = ut_v[ut_sel];
      m_d     = ut_d[ut_sel];
      m_plv   = ut_plv[ut_sel];
      m_mat   = ut_mat[ut_sel];
      m_ppn   = ut_ppn[ut_sel];
      m_ps4m  = ut_ps4m[ut_sel];
    end
    map_pa  = m_ps4m ? {m_ppn[19:10], va_q[21:0]} : {m_ppn, va_q[11:0]};
    pi      = m_found & ~m_v;
    ppi     = m_found & m_v & (crmd_q[1:0] > m_plv);
    pme     = m_found & m_v & ~ppi & type_q[0] & ~m_d;
    map_exc = {pi & type_q[1], pi & type_q[0], pi & type_q[2], pme, ppi, ~m_found};
  end

  always_comb begin
    state_n     = state;
    tlb_s_valid = 1'b0;
    ld_resp     = 1'b0;
    nx_pa       = va_q;
    nx_mat      = '0;
    nx_exc      = '0;
    case (state)
      IDLE: if (req_valid) state_n = CHECK;
      CHECK: begin
        state_n = RESP;
        ld_resp = 1'b1;
        if (crmd_q[3] && !crmd_q[4]) begin
          nx_mat = type_q[2] ? crmd_q[6:5] : crmd_q[8:7];
        end else if (!crmd_q[3] && crmd_q[4]) begin
          if (dmw_hit) begin
            nx_pa  = dmw_pa;
            nx_mat = dmw_mat;
          end else if (ut_hit && !flush) begin
            nx_pa  = map_pa;
            nx_mat = m_mat;
            nx_exc = map_exc;
          end else begin
            ld_resp     = 1'b0;
            tlb_s_valid = 1'b1;
            state_n     = WALK;
          end
        end
      end
      WALK: begin
        state_n = RESP;
        ld_resp = 1'b1;
        nx_pa   = map_pa;
        nx_mat  = m_mat;
        nx_exc  = map_exc;
      end
      RESP: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      va_q   <= '0;
      crmd_q <= '0;
      type_q <= '0;
      dmw_q  <= '0;
      asid_q <= '0;
      pa_q   <= '0;
      mat_q  <= '0;
      exc_q  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        va_q   <= req_va;
        crmd_q <= csr_crmd;
        type_q <= req_type;
        dmw_q  <= csr_dmw;
        asid_q <= csr_asid;
      end
      if (ld_resp) begin
        pa_q  <= PALEN'(nx_pa);
        mat_q <= nx_mat;
        exc_q <= nx_exc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ut_valid <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      ut_valid <= '0;
    end else if (state == WALK && tlb_s_found && tlb_s_v) begin
      ut_valid[victim] <= 1'b1;
      ut_tag[victim]   <= va_q[31:12];
      ut_ps4m[victim]  <= m_ps4m;
      ut_asid[victim]  <= asid_q;
      ut_ppn[victim]   <= tlb_s_ppn;
      ut_plv[victim]   <= tlb_s_plv;
      ut_mat[victim]   <= tlb_s_mat;
      ut_d[victim]     <= tlb_s_d;
      ut_v[victim]     <= tlb_s_v;
      if (!has_free) rr_ptr <= (rr_ptr == IDXW'(UTLB_NUM - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_mmu_xlate_pipe.sv
// Bench for mmu_xlate_pipe: directed scenarios then random traffic against a
// page-table + uTLB-occupancy reference model.
module tb_mmu_xlate_pipe;
  localparam int TLBNUM = 16, UTLB_NUM = 4, NUM_DMW = 2, PALEN = 32;
  localparam logic [2:0] FETCH = 3'b100, LOAD = 3'b010, STORE = 3'b001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, req_valid, req_ready, flush, resp_valid, resp_ready, resp_has_except;
  logic [31:0] req_va, csr_crmd;
  logic [2:0] req_type;
  logic [63:0] csr_dmw;
  logic [9:0] csr_asid, tlb_s_asid;
  logic tlb_s_valid, tlb_s_va_bit12, tlb_s_found, tlb_s_d, tlb_s_v;
  logic [18:0] tlb_s_vppn;
  logic [3:0] tlb_s_index;
  logic [19:0] tlb_s_ppn;
  logic [5:0] tlb_s_ps, resp_except;
  logic [1:0] tlb_s_plv, tlb_s_mat, resp_mat;
  logic [PALEN-1:0] resp_pa;

  mmu_xlate_pipe #(.TLBNUM(TLBNUM), .UTLB_NUM(UTLB_NUM), .NUM_DMW(NUM_DMW), .PALEN(PALEN)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va),
    .req_type(req_type), .csr_crmd(csr_crmd), .csr_dmw(csr_dmw), .csr_asid(csr_asid),
    .flush(flush), .tlb_s_valid(tlb_s_valid), .tlb_s_vppn(tlb_s_vppn),
    .tlb_s_va_bit12(tlb_s_va_bit12), .tlb_s_asid(tlb_s_asid), .tlb_s_found(tlb_s_found),
    .tlb_s_index(tlb_s_index), .tlb_s_ppn(tlb_s_ppn), .tlb_s_ps(tlb_s_ps), .tlb_s_plv(tlb_s_plv),
    .tlb_s_mat(tlb_s_mat), .tlb_s_d(tlb_s_d), .tlb_s_v(tlb_s_v), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_pa(resp_pa), .resp_mat(resp_mat), .resp_except(resp_except),
    .resp_has_except(resp_has_except)
  );

  int checks = 0, errors = 0, walk_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Main TLB contents: either fixed knobs or an 8-region random page table at va[31:22]=0x10..0x17.
  bit use_fixed;
  logic fx_found, fx_v, fx_d, fx_ps4m;
  logic [1:0] fx_plv, fx_mat;
  logic [19:0] fx_ppn;
  logic pt_found [8], pt_v [8], pt_d [8], pt_ps4m [8];
  logic [1:0] pt_plv [8], pt_mat [8];
  logic [19:0] pt_ppn [8];

  task automatic mtlb_lookup(input logic [19:0] vpn, output logic f, output logic v,
                             output logic d, output logic [1:0] plv, output logic [1:0] mat,
                             output logic [19:0] ppn, output logic ps4m);
    int region;
    region = int'(vpn[19:10]);
    if (use_fixed) begin
      f = fx_found; v = fx_v; d = fx_d; plv = fx_plv; mat = fx_mat; ppn = fx_ppn; ps4m = fx_ps4m;
    end else if (region >= 16 && region < 24) begin
      f = pt_found[region-16]; v = pt_v[region-16]; d = pt_d[region-16];
      plv = pt_plv[region-16]; mat = pt_mat[region-16]; ps4m = pt_ps4m[region-16];
      ppn = ps4m ? pt_ppn[region-16] : pt_ppn[region-16] + 20'(vpn[9:0]);
    end else begin
      f = 1'b0; v = vpn[0]; d = vpn[1]; plv = vpn[3:2]; mat = vpn[5:4]; ppn = ~vpn; ps4m = 1'b0;
    end
  endtask

  logic [31:0] cur_va;
  logic [9:0] cur_asid;
  logic pend;
  logic [19:0] pend_vpn;

  always @(negedge clk) begin
    pend = tlb_s_valid;
    pend_vpn = {tlb_s_vppn, tlb_s_va_bit12};
    if (tlb_s_valid) begin
      walk_cnt++;
      check_eq("s_vpn", {44'd0, tlb_s_vppn, tlb_s_va_bit12}, {44'd0, cur_va[31:12]});
      check_eq("s_asid", {54'd0, tlb_s_asid}, {54'd0, cur_asid});
    end
  end

  // Search results are valid only in the cycle after the strobe; other cycles carry noise.
  always @(posedge clk) begin
    logic f, v, d, ps4m;
    logic [1:0] plv, mat;
    logic [19:0] ppn;
    #1;
    tlb_s_index = 4'($urandom);
    if (pend) begin
      mtlb_lookup(pend_vpn, f, v, d, plv, mat, ppn, ps4m);
      tlb_s_found = f; tlb_s_v = v; tlb_s_d = d; tlb_s_plv = plv; tlb_s_mat = mat;
      tlb_s_ppn = ppn; tlb_s_ps = ps4m ? 6'd21 : 6'd12;
    end else begin
      tlb_s_found = 1'($urandom); tlb_s_v = 1'($urandom); tlb_s_d = 1'($urandom);
      tlb_s_plv = 2'($urandom); tlb_s_mat = 2'($urandom); tlb_s_ppn = 20'($urandom);
      tlb_s_ps = 6'($urandom);
    end
  end

  // uTLB occupancy model: which translations are cached and where the next eviction lands.
  bit m_val [UTLB_NUM];
  logic [9:0] m_asid [UTLB_NUM];
  logic [19:0] m_tag [UTLB_NUM], m_ppn [UTLB_NUM];
  logic m_ps4m [UTLB_NUM], m_d [UTLB_NUM];
  logic [1:0] m_plv [UTLB_NUM], m_mat [UTLB_NUM];
  int m_ptr;

  function automatic void model_flush();
    for (int i = 0; i < UTLB_NUM; i++) m_val[i] = 0;
  endfunction

  function automatic int model_find(input logic [31:0] va, input logic [9:0] asid);
    int r = -1;
    for (int i = 0; i < UTLB_NUM; i++)
      if (m_val[i] && m_asid[i] == asid &&
          (m_ps4m[i] ? (m_tag[i] >> 10) == 20'(va >> 22) : m_tag[i] == 20'(va >> 12))) r = i;
    return r;
  endfunction

  function automatic void model_fill(input logic [31:0] va, input logic [9:0] asid,
                                     input logic d, input logic [1:0] plv, input logic [1:0] mat,
                                     input logic [19:0] ppn, input logic ps4m);
    int slot = -1;
    for (int i = 0; i < UTLB_NUM; i++) if (slot < 0 && !m_val[i]) slot = i;
    if (slot < 0) begin
      slot = m_ptr;
      m_ptr = (m_ptr + 1) % UTLB_NUM;
    end
    m_val[slot] = 1; m_asid[slot] = asid; m_tag[slot] = 20'(va >> 12); m_d[slot] = d;
    m_plv[slot] = plv; m_mat[slot] = mat; m_ppn[slot] = ppn; m_ps4m[slot] = ps4m;
  endfunction

  task automatic xact(input logic [31:0] va, input logic [2:0] typ, input logic [31:0] crmd,
                      input logic [9:0] asid, input logic [63:0] dmw, input int flush_c,
                      input int stall);
    logic [31:0] e_pa;
    logic [1:0] e_mat, eplv, emat, plv;
    logic [5:0] e_exc;
    logic f, v, d, ps4m, dhit, ppi, pi;
    logic [19:0] ppn;
    int e_walk, w0, lat, held, hi;
    bit done, rel;
    e_pa = va; e_mat = 2'd0; e_exc = 6'd0; e_walk = 0; plv = crmd[1:0];
    f = 0; v = 0; d = 0; eplv = 0; emat = 0; ppn = 0; ps4m = 0;
    if (flush_c == 0) model_flush();
    if (crmd[3] && !crmd[4]) begin
      e_mat = typ[2] ? crmd[6:5] : crmd[8:7];
    end else if (!crmd[3] && crmd[4]) begin
      dhit = 0;
      for (int i = 0; i < NUM_DMW; i++)
        if (!dhit && va[31:29] == dmw[32*i+29 +: 3] &&
            ((dmw[32*i] && plv == 2'd0) || (dmw[32*i+3] && plv == 2'd3))) begin
          dhit = 1;
          e_pa = {dmw[32*i+25 +: 3], va[28:0]};
          e_mat = dmw[32*i+4 +: 2];
        end
      if (!dhit) begin
        hi = model_find(va, asid);
        if (hi >= 0 && flush_c != 1) begin
          f = 1; v = 1; d = m_d[hi]; eplv = m_plv[hi]; emat = m_mat[hi];
          ppn = m_ppn[hi]; ps4m = m_ps4m[hi];
        end else begin
          e_walk = 1;
          mtlb_lookup(va[31:12], f, v, d, eplv, emat, ppn, ps4m);
        end
        e_pa = ps4m ? (((32'(ppn) << 12) & 32'hFFC0_0000) | (va & 32'h003F_FFFF))
                    : ((32'(ppn) << 12) | (va & 32'h0000_0FFF));
        e_mat = emat;
        pi = f && !v;
        ppi = f && v && (plv > eplv);
        e_exc = {pi && typ[1], pi && typ[0], pi && typ[2], f && v && !ppi && typ[0] && !d, ppi, !f};
      end
    end
    if (flush_c == 1) model_flush();
    if (e_walk != 0 && f && v && flush_c != 2) model_fill(va, asid, d, eplv, emat, ppn, ps4m);
    if (flush_c >= 2) model_flush();

    cur_va = va; cur_asid = asid;
    @(negedge clk);
    check_eq("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1; req_va = va; req_type = typ; csr_crmd = crmd; csr_asid = asid; csr_dmw = dmw;
    flush = (flush_c == 0);
    w0 = walk_cnt;
    @(posedge clk);
    lat = -1; held = 0; done = 0; rel = 0;
    for (int cyc = 1; cyc <= 24 && !(done && cyc > 4); cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        req_valid = 0; req_va = $urandom; csr_crmd = $urandom;
        csr_asid = 10'($urandom); csr_dmw = {$urandom, $urandom};
      end
      flush = (flush_c == cyc);
      if (rel) begin
        resp_ready = 0; rel = 0; done = 1;
        check_eq("resp_after_hs", 64'(resp_valid), 64'd0);
        check_eq("ready_after_hs", 64'(req_ready), 64'd1);
      end else if (!done && resp_valid) begin
        if (lat < 0) begin
          lat = cyc;
          check_eq("latency", 64'(cyc), 64'(e_walk != 0 ? 3 : 2));
        end
        check_eq("req_ready_busy", 64'(req_ready), 64'd0);
        check_eq("pa", 64'(resp_pa), 64'(e_pa));
        check_eq("mat", 64'(resp_mat), 64'(e_mat));
        check_eq("except", 64'(resp_except), 64'(e_exc));
        check_eq("has_except", 64'(resp_has_except), 64'(|e_exc));
        if (held >= stall) begin resp_ready = 1; rel = 1; end
        held++;
      end
    end
    resp_ready = 0; flush = 0;
    check_eq("resp_done", 64'(done), 64'd1);
    check_eq("walks", 64'(walk_cnt - w0), 64'(e_walk));
  endtask

  task automatic flush_pulse();
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;
    model_flush();
  endtask

  task automatic set_fixed(input logic f, input logic v, input logic d, input logic [1:0] plv,
                           input logic [1:0] mat, input logic [19:0] ppn);
    use_fixed = 1; fx_found = f; fx_v = v; fx_d = d; fx_plv = plv; fx_mat = mat;
    fx_ppn = ppn; fx_ps4m = 0;
  endtask

  initial begin
    logic [63:0] dmw_d, dmw_r;
    logic [31:0] crmd, va, w;
    logic [2:0] typ;
    int sel;
    reset = 1; req_valid = 0; req_va = 0; req_type = 0; csr_crmd = 0; csr_dmw = 0;
    csr_asid = 0; flush = 0; resp_ready = 0; cur_va = 0; cur_asid = 0;
    model_flush(); m_ptr = 0;
    dmw_d = {32'h0, 32'h8000_0011};
    set_fixed(1, 1, 1, 2'd0, 2'd1, 20'h00ABC);
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_s_valid", 64'(tlb_s_valid), 64'd0);
    check_eq("rst_pa", 64'(resp_pa), 64'd0);
    check_eq("rst_except", {57'd0, resp_has_except, resp_except}, 64'd0);
    reset = 0;

    // DA, DMW, DMW blocked by PLV
    xact(32'h1C00_0100, LOAD, 32'h0000_0108, 10'h5, dmw_d, -1, 0);
    xact(32'h9000_1234, LOAD, 32'h0000_0010, 10'h5, dmw_d, -1, 0);
    xact(32'h9000_1234, LOAD, 32'h0000_0013, 10'h5, dmw_d, -1, 0);
    // walk then uTLB hit
    xact(32'h0040_0567, LOAD, 32'h0000_0010, 10'h5, dmw_d, -1, 0);
    xact(32'h0040_0FFC, LOAD, 32'h0000_0010, 10'h5, dmw_d, -1, 0);
    // exceptions
    set_fixed(0, 1, 1, 2'd0, 2'd1, 20'h00123);
    xact(32'h0050_0000, LOAD, 32'h0000_0010, 10'h5, dmw_d, -1, 0);
    xact(32'h0050_0000, LOAD, 32'h0000_0010, 10'h5, dmw_d, -1, 0);
    set_fixed(1, 1, 0, 2'd0, 2'd1, 20'h00456);
    xact(32'h0060_0010, STORE, 32'h0000_0010, 10'h5, dmw_d, -1, 0);
    xact(32'h0060_0020, STORE, 32'h0000_0010, 10'h5, dmw_d, -1, 0);
    set_fixed(1, 1, 1, 2'd0, 2'd2, 20'h00789);
    xact(32'h0070_0000, FETCH, 32'h0000_0013, 10'h5, dmw_d, -1, 0);
    set_fixed(1, 0, 1, 2'd0, 2'd2, 20'h00321);
    xact(32'h0080_0000, LOAD, 32'h0000_0010, 10'h5, dmw_d, -1, 0);
    // replacement and flush
    set_fixed(1, 1, 1, 2'd0, 2'd1, 20'h11000);
    flush_pulse();
    for (int i = 0; i < 5; i++) xact(32'h0100_0000 + 32'(i) * 32'h1000, LOAD, 32'h10, 10'h5, dmw_d, -1, 0);
    xact(32'h0100_1000, LOAD, 32'h10, 10'h5, dmw_d, -1, 0);
    xact(32'h0100_0000, LOAD, 32'h10, 10'h5, dmw_d, -1, 0);
    flush_pulse();
    xact(32'h0100_1000, LOAD, 32'h10, 10'h5, dmw_d, -1, 0);
    xact(32'h0100_2000, LOAD, 32'h10, 10'h5, dmw_d, 2, 0);
    xact(32'h0100_2000, LOAD, 32'h10, 10'h5, dmw_d, -1, 0);
    // backpressure
    xact(32'h0100_1004, STORE, 32'h10, 10'h5, dmw_d, -1, 5);
    // reset while walking
    cur_va = 32'h0200_0000; cur_asid = 10'h5;
    @(negedge clk);
    req_valid = 1; req_va = cur_va; req_type = LOAD; csr_crmd = 32'h10; csr_asid = 10'h5;
    csr_dmw = dmw_d;
    @(negedge clk); req_valid = 0;
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    check_eq("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_mid_req_ready", 64'(req_ready), 64'd1);
    model_flush(); m_ptr = 0;
    xact(32'h0100_1000, LOAD, 32'h10, 10'h5, dmw_d, -1, 0);

    // random traffic over the page table
    use_fixed = 0;
    for (int k = 0; k < 8; k++) begin
      pt_found[k] = ($urandom_range(0, 7) != 0); pt_v[k] = ($urandom_range(0, 5) != 0);
      pt_d[k] = 1'($urandom); pt_plv[k] = 2'($urandom); pt_mat[k] = 2'($urandom);
      pt_ps4m[k] = ($urandom_range(0, 2) == 0); pt_ppn[k] = 20'($urandom);
    end
    dmw_r = dmw_d;
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0)
        for (int i = 0; i < NUM_DMW; i++) begin
          w = $urandom; w[31:29] = 3'(4 + i); dmw_r[32*i +: 32] = w;
        end
      crmd = $urandom;
      sel = $urandom_range(0, 9);
      crmd[4:3] = (sel < 2) ? 2'b01 : (sel == 2) ? 2'($urandom_range(0, 1) * 3) : 2'b10;
      if ($urandom_range(0, 4) == 0) begin
        va = $urandom; va[31:29] = 3'($urandom_range(4, 5));
      end else begin
        va = {10'(16 + $urandom_range(0, 4)), 8'd0, 2'($urandom), 12'($urandom)};
      end
      sel = $urandom_range(0, 2);
      typ = (sel == 0) ? FETCH : (sel == 1) ? LOAD : STORE;
      xact(va, typ, crmd, 10'($urandom_range(1, 2)), dmw_r,
           ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
